// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: command encodings, command-word layout,
// batch sizing and the batch-control state type.
package alu_pkg;

  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned RES_W     = 16;
  localparam int unsigned WORD_W    = 24;
  localparam logic [3:0]  CNT_SAT   = 4'd9;

  localparam int unsigned BIT_R   = 23;
  localparam int unsigned BIT_C   = 22;
  localparam int unsigned ADDR_HI = 21;
  localparam int unsigned ADDR_LO = 19;
  localparam int unsigned CMD_HI  = 18;
  localparam int unsigned CMD_LO  = 16;
  localparam int unsigned A_HI    = 15;
  localparam int unsigned A_LO    = 8;
  localparam int unsigned B_HI    = 7;
  localparam int unsigned B_LO    = 0;

  typedef enum logic [2:0] {
    CMD_ADD = 3'd0,
    CMD_SUB = 3'd1,
    CMD_AND = 3'd2,
    CMD_OR  = 3'd3,
    CMD_XOR = 3'd4,
    CMD_SHL = 3'd5,
    CMD_SHR = 3'd6,
    CMD_MUL = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  typedef struct packed {
    logic       r;
    logic       c;
    logic [2:0] addr;
    cmd_e       cmd;
    logic [7:0] a;
    logic [7:0] b;
  } word_t;

  function automatic word_t decode_word(input logic [WORD_W-1:0] w);
    word_t d;
    d.r    = w[BIT_R];
    d.c    = w[BIT_C];
    d.addr = w[ADDR_HI:ADDR_LO];
    d.cmd  = cmd_e'(w[CMD_HI:CMD_LO]);
    d.a    = w[A_HI:A_LO];
    d.b    = w[B_HI:B_LO];
    return d;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Bus between the ALU execute stage and its environment: command stream in,
// result read port and batch status out.
interface alu_exec_stage_if;
  import alu_pkg::*;

  logic              alu_en;
  logic [WORD_W-1:0] in_data;
  logic [2:0]        rd_addr;
  logic [RES_W-1:0]  rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;

  modport master (
    output alu_en, in_data, rd_addr,
    input  rd_data, rd_valid, busy, done
  );

  modport slave (
    input  alu_en, in_data, rd_addr,
    output rd_data, rd_valid, busy, done
  );

endinterface

// File: rtl/alu_core.sv
// Combinational 8-bit ALU with a 16-bit result; operands are zero-extended.
module alu_core
  import alu_pkg::*;
(
  input  cmd_e             cmd,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [RES_W-1:0] result
);

  logic [RES_W-1:0] a_x;
  logic [RES_W-1:0] b_x;

  assign a_x = {{(RES_W-8){1'b0}}, a};
  assign b_x = {{(RES_W-8){1'b0}}, b};

  always_comb begin
    result = '0;
    unique case (cmd)
      CMD_ADD: result = a_x + b_x;
      CMD_SUB: result = a_x - b_x;
      CMD_AND: result = a_x & b_x;
      CMD_OR:  result = a_x | b_x;
      CMD_XOR: result = a_x ^ b_x;
      CMD_SHL: result = a_x << b[2:0];
      CMD_SHR: result = a_x >> b[2:0];
      CMD_MUL: result = a_x * b_x;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline fed by the 8-entry source bank: samples command words,
// runs them through alu_core and stores results in an 8-entry buffer with a registered read port.
module alu_exec_stage
  import alu_pkg::*;
(
  input logic              clk,
  input logic              rst,
  alu_exec_stage_if.slave  bus
);

  logic [3:0]       cnt_q;
  logic             s1_valid_q;
  logic             s1_last_q;
  word_t            s1_q;
  logic [7:0]       chain_q;
  logic [RES_W-1:0] buf_q [NUM_WORDS];
  logic [NUM_WORDS-1:0] valid_q;
  logic [RES_W-1:0] rd_data_q;
  logic             rd_valid_q;
  state_e           state_q, state_d;

  logic             start;
  logic             sample;
  logic             s2_fire;
  logic [7:0]       op_a;
  logic [RES_W-1:0] result;

  assign start   = bus.alu_en && (cnt_q == 4'd0);
  assign sample  = bus.alu_en && (cnt_q >= 4'd1) && (cnt_q <= 4'(NUM_WORDS));
  // A word caught in S1 when alu_en drops is discarded rather than executed.
  assign s2_fire = s1_valid_q && bus.alu_en;
  assign op_a    = s1_q.c ? chain_q : s1_q.a;

  alu_core u_alu_core (
    .cmd    (s1_q.cmd),
    .a      (op_a),
    .b      (s1_q.b),
    .result (result)
  );

  // Counter tracks the upstream bank's read pointer, offset by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (!bus.alu_en) begin
      cnt_q <= 4'd0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= sample;
      if (sample) begin
        s1_q      <= decode_word(bus.in_data);
        s1_last_q <= (cnt_q == 4'(NUM_WORDS));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= 8'd0;
      valid_q <= '0;
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        buf_q[i] <= '0;
      end
    end else if (start) begin
      chain_q <= 8'd0;
      valid_q <= '0;
    end else if (s2_fire) begin
      chain_q <= result[7:0];
      if (s1_q.r) begin
        buf_q[s1_q.addr]   <= result;
        valid_q[s1_q.addr] <= 1'b1;
      end
    end
  end

  // Non-blocking reads naturally return pre-write contents on a same-edge collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= buf_q[bus.rd_addr];
      rd_valid_q <= valid_q[bus.rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.alu_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start) state_d = StBusy;
        StBusy:  if (s2_fire && s1_last_q) state_d = StDone;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state_q == StBusy);
    bus.done     = (state_q == StDone);
    bus.rd_data  = rd_data_q;
    bus.rd_valid = rd_valid_q;
  end

endmodule
